cpu_status: RTL and testbench

Processor status (P) register for the 2A03 CPU core. It captures the carry, zero, sign and overflow flags produced by the ALU, holds the D, I and C flags, and feeds the stored carry back to the ALU carry input. It also builds the pushed status byte for PHP, BRK and interrupts, and produces the interrupt-mask value used by the interrupt poller, including the 6502 one-instruction latency on CLI, SEI and PLP.

---
 rtl/cpu_status.sv | 122 ++++++++++++
 tb/tb_cpu_status.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_status.sv
`default_nettype none
// ============================================================================
// Module      : cpu_status
// Description : 2A03 processor status (P) register with ALU flag capture,
//               push byte and interrupt-mask latency (STATUS_IRQ_DELAY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_status (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_cout,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       alu_ovf,
    input  logic       upd_c,
    input  logic       upd_z,
    input  logic       upd_n,
    input  logic       upd_v,
    input  logic [7:0] flag_set,
    input  logic [7:0] flag_clr,
    input  logic       p_load,
    input  logic       p_rti,
    input  logic [7:0] p_in,
    input  logic       push_b,
    input  logic       instr_done,
    output logic       alu_cin,
    output logic [7:0] p,
    output logic [7:0] p_push,
    output logic       irq_mask
);

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic w_n, w_v, w_d, w_i, w_z, w_c;

    // Priority: bus load, then clear, then set, then ALU capture, else hold.
    function automatic logic f_next(input logic hold, input logic ld_bit,
                                    input logic clr, input logic set,
                                    input logic upd, input logic alu);
        logic v;
        v = hold;
        if (p_load)
            v = ld_bit;
        else if (clr)
            v = 1'b0;
        else if (set)
            v = 1'b1;
        else if (upd)
            v = alu;
        return v;
    endfunction

    always_comb begin
        w_c = f_next(r_c, p_in[0], flag_clr[0], flag_set[0], upd_c, alu_cout);
        w_z = f_next(r_z, p_in[1], flag_clr[1], flag_set[1], upd_z, alu_zero);
        w_i = f_next(r_i, p_in[2], flag_clr[2], flag_set[2], 1'b0,  1'b0);
        w_d = f_next(r_d, p_in[3], flag_clr[3], flag_set[3], 1'b0,  1'b0);
        w_v = f_next(r_v, p_in[6], flag_clr[6], flag_set[6], upd_v, alu_ovf);
        w_n = f_next(r_n, p_in[7], flag_clr[7], flag_set[7], upd_n, alu_sign);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= 1'b0;
            r_v <= 1'b0;
            r_d <= 1'b0;
            r_i <= 1'b1;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else begin
            r_n <= w_n;
            r_v <= w_v;
            r_d <= w_d;
            r_i <= w_i;
            r_z <= w_z;
            r_c <= w_c;
        end
    end

    assign alu_cin = r_c;
    assign p       = {r_n, r_v, 1'b1, 1'b0,   r_d, r_i, r_z, r_c};
    assign p_push  = {r_n, r_v, 1'b1, push_b, r_d, r_i, r_z, r_c};

`ifdef STATUS_IRQ_DELAY_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t r_state;
    logic   r_irq_mask;
    logic   w_unused;

    assign w_unused = &{1'b0, p_in[5:4], flag_set[5:4], flag_clr[5:4]};

    // A poll in the same cycle as the I write belongs to that instruction,
    // so a fresh write always wins over a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_irq_mask <= 1'b1;
        end else if (p_load && p_rti) begin
            r_state    <= ST_IDLE;
            r_irq_mask <= p_in[2];
        end else if (w_i != r_i) begin
            r_state    <= ST_PEND;
        end else if (r_state == ST_PEND && instr_done) begin
            r_state    <= ST_IDLE;
            r_irq_mask <= r_i;
        end
    end

    assign irq_mask = r_irq_mask;
`else
    logic w_unused;

    assign w_unused = &{1'b0, p_rti, instr_done, p_in[5:4],
                        flag_set[5:4], flag_clr[5:4]};
    assign irq_mask = r_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_status
// Description : Self-checking bench for cpu_status against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_status;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_cout, alu_zero, alu_sign, alu_ovf;
    logic       upd_c, upd_z, upd_n, upd_v;
    logic [7:0] flag_set, flag_clr;
    logic       p_load, p_rti;
    logic [7:0] p_in;
    logic       push_b, instr_done;
    logic       alu_cin;
    logic [7:0] p, p_push;
    logic       irq_mask;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_p;
    logic       m_mask;
    logic       m_pend;

    always #5 clk = ~clk;

    cpu_status dut (
        .clk        (clk),
        .rst        (rst),
        .alu_cout   (alu_cout),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .alu_ovf    (alu_ovf),
        .upd_c      (upd_c),
        .upd_z      (upd_z),
        .upd_n      (upd_n),
        .upd_v      (upd_v),
        .flag_set   (flag_set),
        .flag_clr   (flag_clr),
        .p_load     (p_load),
        .p_rti      (p_rti),
        .p_in       (p_in),
        .push_b     (push_b),
        .instr_done (instr_done),
        .alu_cin    (alu_cin),
        .p          (p),
        .p_push     (p_push),
        .irq_mask   (irq_mask)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p"},        p,                 m_p);
        chk({tag, ".p_push"},   p_push,            m_p | {3'b000, push_b, 4'b0000});
        chk({tag, ".alu_cin"},  {7'b0, alu_cin},   {7'b0, m_p[0]});
        chk({tag, ".irq_mask"}, {7'b0, irq_mask},  {7'b0, m_mask});
    endtask

    task automatic model_reset();
        m_p    = 8'h24;
        m_mask = 1'b1;
        m_pend = 1'b0;
    endtask

    // Byte-wide model: apply sources lowest priority first so higher ones overwrite.
    task automatic model_clock();
        logic [7:0] u, a, n;
        logic       old_i;
        old_i = m_p[2];
        u = {upd_n, upd_v, 4'b0000, upd_z, upd_c};
        a = {alu_sign, alu_ovf, 4'b0000, alu_zero, alu_cout};
        n = (m_p & ~u) | (a & u);
        n = n | (flag_set & 8'hCF);
        n = n & ~(flag_clr & 8'hCF);
        if (p_load)
            n = p_in;
        n = (n & 8'hCF) | 8'h20;
        m_p = n;
`ifdef STATUS_IRQ_DELAY_EN
        if (p_load && p_rti) begin
            m_mask = p_in[2];
            m_pend = 1'b0;
        end else if (n[2] != old_i) begin
            m_pend = 1'b1;
        end else if (m_pend && instr_done) begin
            m_mask = n[2];
            m_pend = 1'b0;
        end
`else
        m_mask = n[2];
`endif
    endtask

    task automatic clear_inputs();
        {alu_cout, alu_zero, alu_sign, alu_ovf} = 4'b0;
        {upd_c, upd_z, upd_n, upd_v}             = 4'b0;
        flag_set   = 8'h00;
        flag_clr   = 8'h00;
        p_load     = 1'b0;
        p_rti      = 1'b0;
        p_in       = 8'h00;
        push_b     = 1'b0;
        instr_done = 1'b0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");
        chk("reset_p_const", p, 8'h24);

        // CLI together with instr_done: that poll still sees the old mask
        flag_clr = 8'h04; instr_done = 1'b1;
        step("cli");
        chk("cli_p_const", p, 8'h20);
`ifdef STATUS_IRQ_DELAY_EN
        chk("cli_mask_held", {7'b0, irq_mask}, 8'h01);
`endif
        clear_inputs(); instr_done = 1'b1;
        step("cli_commit");
        chk("cli_mask_commit", {7'b0, irq_mask}, 8'h00);

        // RTI restores I and the mask on the same edge
        clear_inputs(); p_load = 1'b1; p_in = 8'h04; p_rti = 1'b1;
        step("rti");
        chk("rti_mask_now", {7'b0, irq_mask}, 8'h01);

        clear_inputs(); flag_clr = 8'h04;
        step("cli2");
        clear_inputs(); instr_done = 1'b1;
        step("cli2_commit");

        // PLP sets I but the mask waits for the next instruction boundary
        clear_inputs(); p_load = 1'b1; p_in = 8'h04;
        step("plp");
`ifdef STATUS_IRQ_DELAY_EN
        chk("plp_mask_held", {7'b0, irq_mask}, 8'h00);
`endif
        clear_inputs();
        step("plp_wait");
        instr_done = 1'b1;
        step("plp_commit");
        chk("plp_mask_commit", {7'b0, irq_mask}, 8'h01);

        // Reset in the middle of a pending mask change
        clear_inputs(); flag_clr = 8'h04;
        step("pend_for_rst");
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        instr_done = 1'b1;
        step("post_rst_poll");
        chk("post_rst_mask", {7'b0, irq_mask}, 8'h01);

        // ALU capture of all four flags, then Z alone
        clear_inputs();
        alu_cout = 1'b1; alu_zero = 1'b1; alu_sign = 1'b0; alu_ovf = 1'b1;
        {upd_c, upd_z, upd_n, upd_v} = 4'b1111;
        step("alu_all");
        chk("alu_all_const", p, 8'h67);
        chk("alu_cin_const", {7'b0, alu_cin}, 8'h01);
        clear_inputs(); upd_z = 1'b1; alu_zero = 1'b0;
        step("alu_z");
        chk("alu_z_const", p, 8'h65);

        // Priority: load beats set and ALU; clear beats set
        clear_inputs(); p_load = 1'b1; p_in = 8'h00; flag_set = 8'h01;
        upd_c = 1'b1; alu_cout = 1'b1;
        step("prio_load");
        clear_inputs(); flag_set = 8'h01; flag_clr = 8'h01;
        step("prio_clr");
        chk("prio_clr_c", {7'b0, p[0]}, 8'h00);

        // Set and ALU capture on different bits in one cycle
        clear_inputs(); flag_set = 8'h01; upd_z = 1'b1; alu_zero = 1'b1;
        step("mixed");

        // Push byte
        clear_inputs(); p_load = 1'b1; p_in = 8'hC3; p_rti = 1'b1; push_b = 1'b1;
        step("push1");
        chk("push1_const", p_push, 8'hF3);
        clear_inputs();
        #1;
        chk("push0_const", p_push, 8'hE3);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            clear_inputs();
            {alu_cout, alu_zero, alu_sign, alu_ovf} = 4'($urandom);
            {upd_c, upd_z, upd_n, upd_v}             = 4'($urandom);
            if ($urandom_range(0, 3) == 0) flag_set = 8'($urandom);
            if ($urandom_range(0, 3) == 0) flag_clr = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                p_load = 1'b1;
                p_in   = 8'($urandom);
                p_rti  = 1'($urandom);
            end
            push_b     = 1'($urandom);
            instr_done = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
